// File: rtl/pipelined_add_subtractor_if.sv
// Operand/result bundle for the pipelined adder/subtractor.
// The master drives the operands; the slave (the adder) returns the result and flags.
interface pipelined_add_subtractor_if #(
  parameter int NrOfBits = 32
);
  logic                InValid;
  logic                Mode;
  logic [NrOfBits-1:0] DataA;
  logic [NrOfBits-1:0] DataB;
  logic                CarryIn;
  logic                OutValid;
  logic [NrOfBits-1:0] Result;
  logic                CarryOut;
  logic                Overflow;
  logic                Zero;

  modport master (
    output InValid, Mode, DataA, DataB, CarryIn,
    input  OutValid, Result, CarryOut, Overflow, Zero
  );

  modport slave (
    input  InValid, Mode, DataA, DataB, CarryIn,
    output OutValid, Result, CarryOut, Overflow, Zero
  );
endinterface

// File: rtl/pipelined_add_subtractor.sv
// Pipelined two's-complement adder/subtractor: one ChunkBits-wide slice of the
// carry chain per stage, with signed-overflow and zero flags on registered outputs.
module pipelined_add_subtractor #(
  parameter int NrOfBits  = 32,
  parameter int ChunkBits = 8
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         ClockEnable,
  pipelined_add_subtractor_if.slave    bus
);
  localparam int NrOfStages = NrOfBits / ChunkBits;
  localparam int Last       = NrOfStages - 1;

  // Stage inputs: stage 0 takes the bus, stage k takes stage k-1's registers
  logic [NrOfBits-1:0]  aIn    [NrOfStages];
  logic [NrOfBits-1:0]  bIn    [NrOfStages];
  logic [NrOfBits-1:0]  sumIn  [NrOfStages];
  logic                 carryIn[NrOfStages];
  logic                 zeroIn [NrOfStages];
  logic                 validIn[NrOfStages];
  logic                 modeIn [NrOfStages];

  // Stage results
  logic [ChunkBits:0]   chunkSum [NrOfStages];
  logic [NrOfBits-1:0]  sumOut   [NrOfStages];
  logic                 zeroOut  [NrOfStages];
  logic                 msbCarry [NrOfStages];
  logic                 ovfOut   [NrOfStages];

  // Stage registers
  logic [NrOfBits-1:0]  aR     [NrOfStages];
  logic [NrOfBits-1:0]  bR     [NrOfStages];
  logic [NrOfBits-1:0]  sumR   [NrOfStages];
  logic                 carryR [NrOfStages];
  logic                 zeroR  [NrOfStages];
  logic                 validR [NrOfStages];
  logic                 modeR  [NrOfStages];
  logic                 ovfR   [NrOfStages];

  // Route operands into each stage; subtract becomes A + ~B + ~CarryIn in stage 0
  always_comb begin
    aIn[0]     = bus.DataA;
    bIn[0]     = bus.Mode ? ~bus.DataB : bus.DataB;
    sumIn[0]   = {NrOfBits{1'b0}};
    carryIn[0] = bus.CarryIn ^ bus.Mode;
    zeroIn[0]  = 1'b1;
    validIn[0] = bus.InValid;
    modeIn[0]  = bus.Mode;
    for (int k = 1; k < NrOfStages; k++) begin
      aIn[k]     = aR[k-1];
      bIn[k]     = bR[k-1];
      sumIn[k]   = sumR[k-1];
      carryIn[k] = carryR[k-1];
      zeroIn[k]  = zeroR[k-1];
      validIn[k] = validR[k-1];
      modeIn[k]  = modeR[k-1];
    end
  end

  // Resolve chunk k in stage k; carry into the chunk MSB is recovered as sum^a^b
  always_comb begin
    for (int k = 0; k < NrOfStages; k++) begin
      chunkSum[k] = {1'b0, aIn[k][k*ChunkBits +: ChunkBits]}
                  + {1'b0, bIn[k][k*ChunkBits +: ChunkBits]}
                  + {{ChunkBits{1'b0}}, carryIn[k]};
      sumOut[k]   = sumIn[k];
      sumOut[k][k*ChunkBits +: ChunkBits] = chunkSum[k][ChunkBits-1:0];
      zeroOut[k]  = zeroIn[k] & ~(|chunkSum[k][ChunkBits-1:0]);
      msbCarry[k] = chunkSum[k][ChunkBits-1]
                  ^ aIn[k][k*ChunkBits + ChunkBits - 1]
                  ^ bIn[k][k*ChunkBits + ChunkBits - 1];
      ovfOut[k]   = msbCarry[k] ^ chunkSum[k][ChunkBits];
    end
  end

  // Pipeline registers load every enabled cycle; only validR marks real data
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int k = 0; k < NrOfStages; k++) begin
        aR[k]     <= {NrOfBits{1'b0}};
        bR[k]     <= {NrOfBits{1'b0}};
        sumR[k]   <= {NrOfBits{1'b0}};
        carryR[k] <= 1'b0;
        zeroR[k]  <= 1'b0;
        validR[k] <= 1'b0;
        modeR[k]  <= 1'b0;
        ovfR[k]   <= 1'b0;
      end
    end else if (ClockEnable) begin
      for (int k = 0; k < NrOfStages; k++) begin
        aR[k]     <= aIn[k];
        bR[k]     <= bIn[k];
        sumR[k]   <= sumOut[k];
        carryR[k] <= chunkSum[k][ChunkBits];
        zeroR[k]  <= zeroOut[k];
        validR[k] <= validIn[k];
        modeR[k]  <= modeIn[k];
        ovfR[k]   <= ovfOut[k];
      end
    end
  end

  // Output registers capture only completed operations and otherwise hold
  always_ff @(posedge Clock) begin
    if (Reset) begin
      bus.OutValid <= 1'b0;
      bus.Result   <= {NrOfBits{1'b0}};
      bus.CarryOut <= 1'b0;
      bus.Overflow <= 1'b0;
      bus.Zero     <= 1'b0;
    end else if (ClockEnable) begin
      bus.OutValid <= validR[Last];
      if (validR[Last]) begin
        bus.Result   <= sumR[Last];
        bus.CarryOut <= carryR[Last] ^ modeR[Last];
        bus.Overflow <= ovfR[Last];
        bus.Zero     <= zeroR[Last];
      end
    end
  end
endmodule

// File: tb/tb_pipelined_add_subtractor.sv
// Directed and randomized checks of pipelined_add_subtractor against an
// arithmetic reference model with a fixed-latency delay line.
module tb_pipelined_add_subtractor;
  localparam int NrOfBits  = 32;
  localparam int ChunkBits = 8;
  localparam int Latency   = NrOfBits / ChunkBits;

  logic Clock = 1'b0;
  logic Reset;
  logic ClockEnable;

  always #5 Clock = ~Clock;

  pipelined_add_subtractor_if #(.NrOfBits(NrOfBits)) bus ();

  pipelined_add_subtractor #(.NrOfBits(NrOfBits), .ChunkBits(ChunkBits)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .ClockEnable (ClockEnable),
    .bus         (bus.slave)
  );

  typedef struct {
    logic        v;
    logic [31:0] r;
    logic        co;
    logic        ov;
    logic        z;
  } exp_t;

  exp_t delayLine[$];
  exp_t expOut;
  int   tests = 0;
  int   fails = 0;

  // Reference: plain integer arithmetic on the mathematical values
  function automatic exp_t refOp(input logic v, input logic mode,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic cin);
    exp_t   e;
    longint ua;
    longint ub;
    longint sa;
    longint sb;
    longint full;
    longint s;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (mode == 1'b0) begin
      full = ua + ub + longint'(cin);
      s    = sa + sb + longint'(cin);
      e.co = (full > 64'sd4294967295);
    end else begin
      full = ua - ub - longint'(cin);
      s    = sa - sb - longint'(cin);
      e.co = (ua < ub + longint'(cin));
    end
    e.v  = v;
    e.r  = full[31:0];
    e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    e.z  = (e.r == 32'd0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic checkModel();
    chk("model.OutValid", {31'd0, bus.OutValid}, {31'd0, expOut.v});
    chk("model.Result",   bus.Result,            expOut.r);
    chk("model.CarryOut", {31'd0, bus.CarryOut}, {31'd0, expOut.co});
    chk("model.Overflow", {31'd0, bus.Overflow}, {31'd0, expOut.ov});
    chk("model.Zero",     {31'd0, bus.Zero},     {31'd0, expOut.z});
  endtask

  task automatic expectNow(input string tag, input logic v, input logic [31:0] r,
                           input logic co, input logic ov, input logic z);
    chk({tag, ".OutValid"}, {31'd0, bus.OutValid}, {31'd0, v});
    chk({tag, ".Result"},   bus.Result,            r);
    chk({tag, ".CarryOut"}, {31'd0, bus.CarryOut}, {31'd0, co});
    chk({tag, ".Overflow"}, {31'd0, bus.Overflow}, {31'd0, ov});
    chk({tag, ".Zero"},     {31'd0, bus.Zero},     {31'd0, z});
  endtask

  // One clock: drive inputs, update the model at the edge, compare 1 time unit later
  task automatic cycle(input logic ce, input logic rst, input logic v, input logic mode,
                       input logic [31:0] a, input logic [31:0] b, input logic cin);
    exp_t e;
    ClockEnable = ce;
    Reset       = rst;
    bus.InValid = v;
    bus.Mode    = mode;
    bus.DataA   = a;
    bus.DataB   = b;
    bus.CarryIn = cin;
    @(posedge Clock);
    if (rst) begin
      delayLine = {};
      for (int i = 0; i < Latency; i++) delayLine.push_back(refOp(1'b0, 1'b0, 32'd0, 32'd0, 1'b0));
      expOut = '{v: 1'b0, r: 32'd0, co: 1'b0, ov: 1'b0, z: 1'b0};
    end else if (ce) begin
      delayLine.push_back(refOp(v, mode, a, b, cin));
      e = delayLine.pop_front();
      expOut.v = e.v;
      if (e.v) begin
        expOut.r  = e.r;
        expOut.co = e.co;
        expOut.ov = e.ov;
        expOut.z  = e.z;
      end
    end
    #1;
    checkModel();
  endtask

  task automatic bubble();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic randOp(input logic ce, input logic v);
    cycle(ce, 1'b0, v, 1'($urandom_range(0, 1)), 32'($urandom), 32'($urandom),
          1'($urandom_range(0, 1)));
  endtask

  initial begin
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    expectNow("reset", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

    // 5 - 3 with exact latency
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'd5, 32'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      bubble();
      chk("lat.OutValidLow", {31'd0, bus.OutValid}, 32'd0);
    end
    bubble();
    expectNow("sub5m3", 1'b1, 32'd2, 1'b0, 1'b0, 1'b0);

    // Boundary operations back to back, mixed add/sub
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_0001, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    bubble();
    expectNow("sub0m1",     1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    bubble();
    expectNow("subMinm1",   1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    bubble();
    expectNow("addRipple",  1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    bubble();
    expectNow("addMaxp1",   1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    bubble();
    chk("bubbleAfter.OutValid", {31'd0, bus.OutValid}, 32'd0);

    // Random stream with bubbles
    for (int i = 0; i < 1000; i++) randOp(1'b1, 1'($urandom_range(0, 3) != 0));
    for (int i = 0; i < Latency; i++) bubble();

    // ClockEnable low with operations in flight
    randOp(1'b1, 1'b1);
    randOp(1'b1, 1'b1);
    randOp(1'b1, 1'b1);
    bubble();
    bubble();
    for (int i = 0; i < 3; i++) randOp(1'b0, 1'b1);
    for (int i = 0; i < Latency + 1; i++) bubble();

    // Reset mid-stream with ClockEnable high
    randOp(1'b1, 1'b1);
    randOp(1'b1, 1'b1);
    randOp(1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'd7, 32'd9, 1'b0);
    expectNow("midReset", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'd1, 32'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      bubble();
      chk("postReset.OutValidLow", {31'd0, bus.OutValid}, 32'd0);
    end
    bubble();
    expectNow("postReset", 1'b1, 32'd3, 1'b0, 1'b0, 1'b0);

    // Reset wins over ClockEnable low
    randOp(1'b1, 1'b1);
    randOp(1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'd4, 32'd4, 1'b0);
    expectNow("resetCeLow", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < Latency + 1; i++) bubble();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
